mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It owns the HI/LO registers.
- Executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Exposes start/busy to the stall unit, which holds any mult/div-class instruction in D while the unit is occupied.
- It is the responder end of the stall contract: it produces the occupancy condition that the stall unit consumes.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after the start cycle.
- DIV_CYCLES, 10, busy cycles for div/divu after the start cycle.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- E_mdOp  input  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
- E_A  input  32  forwarded rs value.
- E_B  input  32  forwarded rt value.
- start  output  1  combinational; 1 when E_mdOp is MULT/MULTU/DIV/DIVU and state==IDLE.
- busy  output  1  registered; 1 while an operation is in flight.
- E_mdOut  output  32  combinational; HI when E_mdOp==MFHI, LO when MFLO, else 0.
- HI  output  32  architectural HI (debug/trace).
- LO  output  32  architectural LO (debug/trace).

Behaviour:
- Reset: state=IDLE, busy=0, cnt=0, HI=0, LO=0, pending results=0. Reset mid-operation aborts the operation; HI/LO read 0 on the next cycle.
- States:
  - IDLE -> BUSY on start.
  - BUSY -> IDLE when cnt==1 at a clock edge.
- Start cycle (IDLE, start=1):
  - Capture the full result into pendHI/pendLO.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1 at the edge.
- In BUSY:
  - cnt decrements each cycle.
  - At the edge where cnt==1: commit HI<=pendHI, LO<=pendLO; busy falls; state goes to IDLE.
  - Net timing: busy is high for exactly N cycles; a mfhi/mflo issued N+1 cycles after start sees the new value.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
  - MULTU: unsigned 32x32 -> 64; same HI/LO split.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (E_B==0), signed or unsigned: the op runs its full latency; HI/LO are unchanged at commit.
- MTHI/MTLO:
  - In IDLE, write HI<=E_A or LO<=E_A at the edge. Takes effect the next cycle; no busy.
  - In BUSY, ignored (E_mdOp is stall-guaranteed not to present them then).
- MFHI/MFLO: a pure combinational read of the current registers; never stalls inside this block.
- Start request while BUSY: ignored; start=0, state unchanged. The stall unit guarantees this by stalling D when (start|busy) and the D instruction is any MD-class op.
- Simultaneous cases:
  - Commit edge with a new MD op present in E is impossible by the stall contract.
  - If it occurs anyway, the commit wins and the new op is dropped.
- No flush input: ops in E are architecturally committed once start fires.

Decomposition:
- Shared package mdu_pkg holds:
  - op-code localparams (MD_NONE..MD_MTLO, width 4);
  - default MULT_CYCLES/DIV_CYCLES;
  - an is_md_op function reused by the stall unit decode.
- One sub-module, mdu_arith: combinational; inputs op, A, B; outputs 64-bit {hi,lo} and a div_by_zero flag.
- The mdu top holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> start=1 for one cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001; MFLO next cycle gives E_mdOut=0x00000001.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then DIVU 7/0 -> HI/LO unchanged after 10 cycles.
- MTHI A=0x12345678, then MFHI next cycle -> E_mdOut=0x12345678, busy stays 0. MTLO presented while busy -> LO unchanged.
- DIV started, then reset=0 asserted at busy cycle 3 -> next cycle busy=0, HI=LO=0, state IDLE; a later MULT 2*3 completes normally with LO=6.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. A second MULT held on E_mdOp during busy -> start=0 and no restart until busy falls.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the multiply/divide unit. Holds the
//                E-stage MD op-code encoding, the default operation latencies
//                and decode helpers that the MDU and the stall unit share.
//  Contents    : MD_* op codes (4 bits), MULT/DIV default latencies,
//                is_md_op(), is_md_start_op()
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int unsigned MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // Any op that touches HI/LO; the stall unit holds these in D while the
    // unit is starting or busy. Codes 9-15 decode as NONE.
    function automatic logic is_md_op(input logic [MD_OP_W-1:0] op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

    // Ops that occupy the unit for multiple cycles.
    function automatic logic is_md_start_op(input logic [MD_OP_W-1:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Combinational 32x32 arithmetic core for the MDU. Produces the
//                full {HI,LO} result of mult/multu/div/divu in one evaluation;
//                the top-level sequencer models the architectural latency.
//  Ports       : i_op          - MD op code
//                i_a, i_b      - rs / rt operands
//                o_result      - {HI,LO}; zero for non-arithmetic ops
//                o_div_by_zero - div/divu with i_b == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MD_OP_W-1:0] i_op,
    input  logic [31:0]        i_a,
    input  logic [31:0]        i_b,
    output logic [63:0]        o_result,
    output logic               o_div_by_zero
);

    logic        w_is_div;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_safe_b;
    logic [31:0] w_safe_mag_b;
    logic [31:0] w_uq_s;
    logic [31:0] w_ur_s;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;

    assign w_is_div      = (i_op == MD_DIV) || (i_op == MD_DIVU);
    assign o_div_by_zero = w_is_div && (i_b == 32'd0);

    // Operands widened to 64 bits before multiplying so the product is
    // computed at full width; the low 64 bits of a 64x64 product are exact.
    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide on magnitudes. |0x80000000| is 0x80000000 as an unsigned
    // value, so the 0x80000000 / -1 overflow case yields 0x80000000 with a
    // zero remainder without special handling.
    assign w_neg_a      = i_a[31];
    assign w_neg_b      = i_b[31];
    assign w_mag_a      = w_neg_a ? (32'd0 - i_a) : i_a;
    assign w_mag_b      = w_neg_b ? (32'd0 - i_b) : i_b;

    // Divisor forced non-zero so the dividers never see zero; the result is
    // discarded by the sequencer in that case.
    assign w_safe_b     = (i_b == 32'd0) ? 32'd1 : i_b;
    assign w_safe_mag_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;

    assign w_uq_s = w_mag_a / w_safe_mag_b;
    assign w_ur_s = w_mag_a % w_safe_mag_b;
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign w_q_s  = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq_s) : w_uq_s;
    assign w_r_s  = w_neg_a ? (32'd0 - w_ur_s) : w_ur_s;

    assign w_q_u  = i_a / w_safe_b;
    assign w_r_u  = i_a % w_safe_b;

    always_comb begin
        o_result = 64'd0;
        case (i_op)
            MD_MULT:  o_result = w_prod_s;
            MD_MULTU: o_result = w_prod_u;
            MD_DIV:   o_result = {w_r_s, w_q_s};
            MD_DIVU:  o_result = {w_r_u, w_q_u};
            default:  o_result = 64'd0;
        endcase
    end

endmodule : mdu_arith
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Multi-cycle multiply/divide unit for the E stage. Owns the
//                architectural HI/LO registers. A mult/div computes its result
//                at the start cycle, holds it in pending registers and commits
//                it to HI/LO after MULT_CYCLES / DIV_CYCLES busy cycles.
//  Ports       : clk      - clock, rising edge
//                reset    - synchronous, active-low
//                E_mdOp   - E-stage MD op code
//                E_A,E_B  - forwarded rs / rt values
//                start    - mult/div accepted this cycle (comb)
//                busy     - operation in flight (registered)
//                E_mdOut  - HI for mfhi, LO for mflo, else 0 (comb)
//                HI, LO   - architectural registers (trace)
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [MD_OP_W-1:0]  E_mdOp,
    input  logic [31:0]         E_A,
    input  logic [31:0]         E_B,
    output logic                start,
    output logic                busy,
    output logic [31:0]         E_mdOut,
    output logic [31:0]         HI,
    output logic [31:0]         LO
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_we;

    logic               w_start;
    logic               w_is_div;
    logic               w_last;
    logic [63:0]        w_result;
    logic               w_div_by_zero;

    mdu_arith u_arith (
        .i_op          (E_mdOp),
        .i_a           (E_A),
        .i_b           (E_B),
        .o_result      (w_result),
        .o_div_by_zero (w_div_by_zero)
    );

    assign w_start  = (r_state == c_ST_IDLE) && is_md_start_op(E_mdOp);
    assign w_is_div = (E_mdOp == MD_DIV) || (E_mdOp == MD_DIVU);
    assign w_last   = (r_state == c_ST_BUSY) && (r_cnt == c_CNT_ONE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start) w_state_next = c_ST_BUSY;
            c_ST_BUSY: if (w_last)  w_state_next = c_ST_IDLE;
            default:                w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else if (w_start) begin
            r_pend_hi <= w_result[63:32];
            r_pend_lo <= w_result[31:0];
            // Divide by zero still occupies the unit but leaves HI/LO alone.
            r_pend_we <= ~w_div_by_zero;
            r_cnt     <= w_is_div ? c_DIV_LOAD : c_MULT_LOAD;
        end else if (r_state == c_ST_BUSY) begin
            // Any op presented while busy is dropped; the commit always wins.
            r_cnt <= r_cnt - c_CNT_ONE;
            if (w_last && r_pend_we) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else begin
            if (E_mdOp == MD_MTHI) r_hi <= E_A;
            if (E_mdOp == MD_MTLO) r_lo <= E_A;
        end
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        E_mdOut = 32'd0;
        if (E_mdOp == MD_MFHI)      E_mdOut = r_hi;
        else if (E_mdOp == MD_MFLO) E_mdOut = r_lo;
    end

    assign start = w_start;
    assign busy  = (r_state == c_ST_BUSY);
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule : mdu
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu
//  Description : Self-checking bench for mdu. Expected HI/LO results are
//                pushed to a scoreboard queue when an op is issued and popped
//                and compared when busy falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;
    import mdu_pkg::*;

    localparam int c_MULT_N = 5;
    localparam int c_DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  E_mdOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        start;
    logic        busy;
    logic [31:0] E_mdOut;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_checks;
    int          n_fails;

    mdu #(
        .MULT_CYCLES (c_MULT_N),
        .DIV_CYCLES  (c_DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .E_mdOp  (E_mdOp),
        .E_A     (E_A),
        .E_B     (E_B),
        .start   (start),
        .busy    (busy),
        .E_mdOut (E_mdOut),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the architectural {HI,LO} after one op.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input exp_t cur);
        exp_t   r;
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint rm;
        logic [63:0] up;
        r  = cur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT: begin
                p = sa * sb;
                r = exp_t'(p);
            end
            MD_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                r  = exp_t'(up);
            end
            MD_DIV: if (b != 32'd0) begin
                q  = sa / sb;
                rm = sa % sb;
                r.hi = rm[31:0];
                r.lo = q[31:0];
            end
            MD_DIVU: if (b != 32'd0) begin
                r.hi = a % b;
                r.lo = a / b;
            end
            default: r = cur;
        endcase
        return r;
    endfunction

    // Issue a mult/div, hold hold_op on E_mdOp while busy, count busy cycles
    // and compare the committed HI/LO against the scoreboard.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [3:0] hold_op,
                         input logic [31:0] hold_a);
        int   cyc;
        exp_t e;
        exp_t cur;
        E_mdOp = op;
        E_A    = a;
        E_B    = b;
        #1;
        check({tag, " start"}, 32'(start), 32'd1);
        cur.hi = m_hi;
        cur.lo = m_lo;
        e = model(op, a, b, cur);
        sb_q.push_back(e);
        tick();
        E_mdOp = hold_op;
        E_A    = hold_a;
        #1;
        cyc = 0;
        while (busy && cyc < 40) begin
            if (start) begin
                n_checks++;
                n_fails++;
                $display("FAIL %s restart: got start=1 expected start=0 while busy", tag);
            end
            cyc++;
            tick();
        end
        E_mdOp = MD_NONE;
        check({tag, " busy cycles"}, 32'(cyc), 32'(n));
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, " HI"}, HI, e.hi);
            check({tag, " LO"}, LO, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        reset    = 1'b0;
        E_mdOp   = MD_NONE;
        E_A      = 32'd0;
        E_B      = 32'd0;
        repeat (3) tick();
        reset = 1'b1;
        #1;

        check("reset busy", 32'(busy), 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        check("reset start", 32'(start), 32'd0);
        check("idle mdOut", E_mdOut, 32'd0);

        issue("mult -2*3", MD_MULT, 32'hFFFF_FFFE, 32'd3, c_MULT_N, MD_NONE, 32'd0);
        check("mult HI const", HI, 32'hFFFF_FFFF);
        check("mult LO const", LO, 32'hFFFF_FFFA);

        issue("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_MULT_N, MD_NONE, 32'd0);
        E_mdOp = MD_MFLO;
        #1;
        check("mflo after multu", E_mdOut, 32'h0000_0001);
        E_mdOp = MD_NONE;
        tick();

        issue("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, c_DIV_N, MD_NONE, 32'd0);
        check("div LO const", LO, 32'hFFFF_FFFD);
        check("div HI const", HI, 32'hFFFF_FFFF);

        issue("divu 7/0", MD_DIVU, 32'd7, 32'd0, c_DIV_N, MD_NONE, 32'd0);
        check("div0 HI kept", HI, 32'hFFFF_FFFF);
        check("div0 LO kept", LO, 32'hFFFF_FFFD);

        E_mdOp = MD_MTHI;
        E_A    = 32'h1234_5678;
        #1;
        check("mthi start", 32'(start), 32'd0);
        tick();
        E_mdOp = MD_MFHI;
        #1;
        check("mfhi after mthi", E_mdOut, 32'h1234_5678);
        check("mthi busy", 32'(busy), 32'd0);
        m_hi   = 32'h1234_5678;
        E_mdOp = MD_NONE;
        tick();

        // mtlo held on E while busy must be ignored.
        issue("mult mtlo-held", MD_MULT, 32'd3, 32'd4, c_MULT_N, MD_MTLO, 32'hDEAD_BEEF);
        check("mtlo ignored LO", LO, 32'd12);

        // Overflow divide with a second mult waiting on E the whole time.
        issue("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c_DIV_N, MD_MULT, 32'd9);
        check("div ovf LO const", LO, 32'h8000_0000);
        check("div ovf HI const", HI, 32'd0);
        tick();
        check("no restart", 32'(busy), 32'd0);

        // Put non-zero values in HI/LO so the mid-op reset clear is visible.
        E_mdOp = MD_MTHI;
        E_A    = 32'hAAAA_5555;
        tick();
        E_mdOp = MD_MTLO;
        E_A    = 32'h5555_AAAA;
        tick();
        E_mdOp = MD_DIV;
        E_A    = 32'd100;
        E_B    = 32'd7;
        tick();
        E_mdOp = MD_NONE;
        check("pre-reset busy", 32'(busy), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset HI", HI, 32'd0);
        check("mid reset LO", LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (12) tick();
        check("post reset stays idle", 32'(busy), 32'd0);
        check("post reset LO", LO, 32'd0);

        issue("mult 2*3", MD_MULT, 32'd2, 32'd3, c_MULT_N, MD_NONE, 32'd0);
        check("mult 2*3 LO const", LO, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mdu
`default_nettype wire
